// File: rtl/bus_arbiter_bcast_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_bcast_rr
//
// Shared-bus arbiter between `drvrs` agent FIFOs. It picks one pending agent,
// pops its head packet, decodes the destination ID in the packet's top ID_W
// bits and pushes the packet to one agent (unicast) or to every agent except
// the source (broadcast). Packets that cannot be delivered are dropped.
// One packet moves every 4 cycles: IDLE -> POP -> CHECK -> PUSH -> IDLE.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   pndng     [drvrs]          agent i FIFO non-empty
//   D_pop     [drvrs*pckg_sz]  flat; slice i is the head of agent i FIFO
//   pop       [drvrs]          one-hot pop strobe to the agent FIFOs
//   push      [drvrs]          push strobe; multi-hot on broadcast
//   D_push    [pckg_sz]        shared bus data, held until the next CHECK
//   busy                       high while the FSM is outside IDLE
//   drop                       one-cycle pulse when a packet is discarded
//   pkt_cnt   [CNT_W]          delivered packets, saturating
//   drop_cnt  [CNT_W]          dropped packets, saturating
// -----------------------------------------------------------------------------
module bus_arbiter_bcast_rr #(
    parameter int                drvrs     = 4,
    parameter int                pckg_sz   = 16,
    parameter int                ID_W      = 8,
    parameter logic [ID_W-1:0]   broadcast = {ID_W{1'b1}},
    parameter int                MODE      = 0,
    parameter int                CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic                       busy,
    output logic                       drop,
    output logic [CNT_W-1:0]           pkt_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int IDX_W = $clog2(drvrs);
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        CHECK = 2'd2,
        PUSH  = 2'd3
    } state_t;

    state_t               state,      state_nxt;
    logic [IDX_W-1:0]     rr_ptr,     rr_nxt;
    logic [IDX_W-1:0]     win,        win_nxt;
    logic [pckg_sz-1:0]   data,       data_nxt;
    logic                 delivered,  delivered_nxt;
    logic [drvrs-1:0]     pop_nxt;
    logic [drvrs-1:0]     push_nxt;
    logic [pckg_sz-1:0]   D_push_nxt;
    logic                 busy_nxt;
    logic                 drop_nxt;
    logic [CNT_W-1:0]     pkt_cnt_nxt;
    logic [CNT_W-1:0]     drop_cnt_nxt;

    logic [IDX_W-1:0]     grant;
    logic                 grant_found;
    logic [SUM_W-1:0]     cand;
    logic [ID_W-1:0]      dst;
    logic                 is_bcast;
    logic                 is_ucast;

    // -------------------------------------------------------------------------
    // Winner selection. Round-robin scans upward from rr_ptr with wrap-around;
    // fixed priority takes the lowest pending index.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        if (MODE == 0) begin
            for (int k = 0; k < drvrs; k++) begin
                cand = {1'b0, rr_ptr} + SUM_W'(k);
                if (cand >= SUM_W'(drvrs))
                    cand = cand - SUM_W'(drvrs);
                if (!grant_found && pndng[cand[IDX_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant       = cand[IDX_W-1:0];
                end
            end
        end else begin
            for (int k = drvrs - 1; k >= 0; k--) begin
                if (pndng[k]) begin
                    grant_found = 1'b1;
                    grant       = IDX_W'(k);
                end
            end
        end
    end

    // Destination decode of the captured packet.
    assign dst      = data[pckg_sz-1 -: ID_W];
    assign is_bcast = (dst == broadcast);
    assign is_ucast = !is_bcast && (int'(dst) < drvrs) && (int'(dst) != int'(win));

    // -------------------------------------------------------------------------
    // Next-state and next-output logic. All outputs are registered from here.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        win_nxt       = win;
        data_nxt      = data;
        delivered_nxt = delivered;
        pop_nxt       = '0;
        push_nxt      = '0;
        drop_nxt      = 1'b0;
        D_push_nxt    = D_push;
        pkt_cnt_nxt   = pkt_cnt;
        drop_cnt_nxt  = drop_cnt;

        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    pop_nxt[grant] = 1'b1;
                    win_nxt        = grant;
                    if (MODE == 0)
                        rr_nxt = (grant == IDX_W'(drvrs - 1)) ? '0 : grant + 1'b1;
                    state_nxt = POP;
                end
            end

            POP: begin
                // The pop strobe is already on the bus; capture the head the
                // FIFO is presenting, whether or not pndng is still high.
                for (int i = 0; i < drvrs; i++) begin
                    if (i == int'(win))
                        data_nxt = D_pop[i*pckg_sz +: pckg_sz];
                end
                state_nxt = CHECK;
            end

            CHECK: begin
                for (int i = 0; i < drvrs; i++) begin
                    if (is_bcast)
                        push_nxt[i] = (i != int'(win));
                    else if (is_ucast)
                        push_nxt[i] = (i == int'(dst));
                end
                delivered_nxt = is_bcast || is_ucast;
                if (!(is_bcast || is_ucast)) begin
                    drop_nxt = 1'b1;
                    if (drop_cnt != '1)
                        drop_cnt_nxt = drop_cnt + 1'b1;
                end
                D_push_nxt = data;
                state_nxt  = PUSH;
            end

            PUSH: begin
                if (delivered && pkt_cnt != '1)
                    pkt_cnt_nxt = pkt_cnt + 1'b1;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase

        // busy is registered, so it follows the state being entered.
        busy_nxt = (state_nxt != IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win       <= '0;
            data      <= '0;
            delivered <= 1'b0;
            pop       <= '0;
            push      <= '0;
            D_push    <= '0;
            busy      <= 1'b0;
            drop      <= 1'b0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            win       <= win_nxt;
            data      <= data_nxt;
            delivered <= delivered_nxt;
            pop       <= pop_nxt;
            push      <= push_nxt;
            D_push    <= D_push_nxt;
            busy      <= busy_nxt;
            drop      <= drop_nxt;
            pkt_cnt   <= pkt_cnt_nxt;
            drop_cnt  <= drop_cnt_nxt;
        end
    end

endmodule

// File: doc/bus_arbiter_bcast_rr.md
Name: bus_arbiter_bcast_rr

Overview:
- Parametrised successor of the shared-bus generator/arbiter. Connects `drvrs` agent FIFOs over one shared `pckg_sz`-bit bus.
- Arbitrates among pending agents, pops one packet and decodes its destination ID field.
- Delivers the packet as unicast or broadcast to the destination agents' FIFOs.
- Adds over the previous generation: selectable arbitration mode, explicit drop handling, and packet/drop counters.

Parameters:
- drvrs, 4, number of agents (2..16)
- pckg_sz, 16, packet width in bits; must be > ID_W
- ID_W, 8, destination ID field width; field occupies packet bits [pckg_sz-1 -: ID_W]
- broadcast, {ID_W{1'b1}}, destination ID meaning "all agents except source"
- MODE, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
- CNT_W, 16, width of pkt_cnt and drop_cnt

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pndng  in  drvrs  agent i FIFO non-empty
- D_pop  in  drvrs*pckg_sz  flat; slice i = head of agent i FIFO
- pop  out  drvrs  one-hot pop strobe to agent FIFOs
- push  out  drvrs  push strobe to agent FIFOs; multi-hot on broadcast
- D_push  out  pckg_sz  shared bus data, valid while any push bit high
- busy  out  1  high whenever FSM not in IDLE
- drop  out  1  one-cycle pulse when a packet is discarded
- pkt_cnt  out  CNT_W  delivered-packet count, saturating
- drop_cnt  out  CNT_W  dropped-packet count, saturating

Behaviour:
- Reset (async assert, sync release):
  - pop, push, D_push, busy, drop, pkt_cnt and drop_cnt all go to 0.
  - Round-robin pointer goes to 0; FSM goes to IDLE.
  - Reset asserted mid-transfer aborts the transfer with no push. A packet already popped is lost and is not counted.
- All outputs are registered.
- FSM states: IDLE -> POP -> CHECK -> PUSH -> IDLE.
- IDLE: at edge E0, if pndng != 0, pick winner w and register pop <= onehot(w); go to POP. Otherwise stay.
- Winner selection:
  - MODE=0: first set pndng bit searching upward from rr_ptr, with wrap-around. After a grant, rr_ptr <= (w+1) mod drvrs.
  - MODE=1: lowest set pndng index; rr_ptr is unused.
- POP (pop[w] high for exactly one cycle): at E1, capture D_pop slice w into an internal register and drop pop. Pop is issued even if pndng[w] fell after E0.
- CHECK: at E2, decode dst = data[pckg_sz-1 -: ID_W].
  - dst == broadcast: push <= all ones except bit w.
  - dst < drvrs and dst != w: push <= onehot(dst).
  - Otherwise (out of range, or self-addressed): push <= 0, drop <= 1 for one cycle, drop_cnt++.
  - D_push <= data in every case.
- PUSH: push high exactly one cycle. At E3 clear push, pkt_cnt++ if delivered, return to IDLE. D_push holds its value until the next CHECK.
- Latency and throughput: pop is high one cycle after pndng is sampled; push is high three cycles after pndng is sampled. Throughput is one packet per 4 cycles.
- The next arbitration happens at E4, with pndng re-sampled.
- Counters saturate at 2^CNT_W-1 with no wrap.
- Simultaneous requests: exactly one grant per transaction; other requesters wait. Under MODE=0 no agent waits more than drvrs-1 transactions.
- busy = (state != IDLE).

Test Plan:
- Reset mid-POP: assert reset while pop[1]=1 → all outputs 0 immediately (async), no push follows, pkt_cnt=0, drop_cnt=0.
- Unicast: drvrs=4, pndng=0010, D_pop slice1=16'h03AB → pop=0010 one cycle later, push=1000 with D_push=16'h03AB three cycles after sampling, pkt_cnt=1.
- Broadcast: agent 2 sends 16'hFF55 → push=1011 for one cycle, D_push=16'hFF55, pkt_cnt increments once.
- Drops: agent 0 sends 16'h0711 (dst=7≥4), then 16'h0022 (self-addressed) → two drop pulses, push stays 0, drop_cnt=2, pkt_cnt unchanged.
- Round-robin fairness (MODE=0): pndng=1111 held for 8 transactions with valid destinations → grant order 0,1,2,3,0,1,2,3. Same stimulus with MODE=1 → grants 0 every time.
- Saturation: CNT_W=4, 20 valid packets → pkt_cnt stops at 15; simultaneous requests never produce multi-hot pop.
